telephone_trunk_ctrl: RTL and testbench
=======================================

// Module: telephone_trunk_ctrl
// PURPOSE
//   Multi-line telephone call controller: N_LINES independent per-line call FSMs sharing MAX_TRUNKS
//   outgoing trunks. Dial/call timeout counters are internal and parameterised; no external count
//   inputs. Adds trunk admission (BUSY state) and dial-abort via cancel. Sits between the line
//   interface (keypad/hook events) and the tone/status drivers.
// PARAMETERS
//   N_LINES       4    number of subscriber lines (>=1)
//   MAX_TRUNKS    2    simultaneous lines allowed in DIAL or IN_CALL (1..N_LINES)
//   DIAL_TIMEOUT  5    cycles a line may remain in DIAL before timing out (>=2)
//   CALL_TIMEOUT  250  cycles a line may remain in IN_CALL before timing out (>=2)
// PORTS
//   pclk          in   1                clock, all state on rising edge
//   preset        in   1                asynchronous, active-high reset
//   dial          in   N_LINES          per-line off-hook/dial request, level
//   pickup_call   in   N_LINES          per-line far end answered
//   end_call      in   N_LINES          per-line hang-up during call
//   cancel        in   N_LINES          per-line return-to-idle from DIAL/timeout/BUSY states
//   dial_tone     out  N_LINES          line in DIAL
//   in_call       out  N_LINES          line in IN_CALL
//   dial_timeout  out  N_LINES          line in DIAL_TO
//   call_ended    out  N_LINES          line in END_CALL or CALL_TO
//   call_timeout  out  N_LINES          line in CALL_TO
//   busy_tone     out  N_LINES          line in BUSY (no trunk granted)
//   active_calls  out  $clog2(N_LINES+1) number of lines currently in DIAL or IN_CALL
// BEHAVIOUR
//   Reset: every line IDLE, every timer 0, all outputs 0, active_calls 0. Asserting preset mid-call
//     drops every line to IDLE immediately and frees all trunks.
//   Outputs: Moore decode of each line's registered state (no input-to-output path).
//   Per-line states / next-state (evaluated every cycle, priority left to right):
//     IDLE    : dial & granted -> DIAL; dial & !granted -> BUSY; else IDLE
//     DIAL    : pickup_call -> IN_CALL; cancel -> IDLE; tmr==DIAL_TIMEOUT-1 -> DIAL_TO; else DIAL
//     IN_CALL : end_call -> END_CALL; tmr==CALL_TIMEOUT-1 -> CALL_TO; else IN_CALL
//     END_CALL: -> IDLE (exactly one cycle)
//     DIAL_TO, CALL_TO, BUSY: cancel -> IDLE; else hold
//   Timer: per line, width $clog2(CALL_TIMEOUT); cleared to 0 on every state change, +1 each
//     cycle the state holds. A line stays exactly DIAL_TIMEOUT cycles in DIAL (CALL_TIMEOUT in
//     IN_CALL) when nothing else fires. Pickup on the timeout cycle wins (-> IN_CALL);
//     end_call on the timeout cycle wins (-> END_CALL). Timer never wraps (state exits first).
//   Trunk admission: free = MAX_TRUNKS - active_calls (registered value). Among lines in IDLE
//     with dial=1 in the same cycle, the lowest-index `free` lines are granted; the rest go BUSY.
//     free==0 -> every requester goes BUSY. A trunk released this cycle (line leaving
//     DIAL/IN_CALL) is available to requesters from the next cycle only.
//   active_calls: registered, equals popcount of lines in DIAL|IN_CALL; never exceeds MAX_TRUNKS.
//   Lines are otherwise fully independent; inputs of a line are ignored in states not listed above.
//   Encoding: 3-bit per-line state; unused codes return to IDLE on the next edge.
// TESTING
//   1. Reset, dial[0]=1 one cycle -> dial_tone[0]=1 next cycle, active_calls=1; hold 5 cycles no
//      pickup -> dial_timeout[0]=1 on cycle 6, active_calls=0; cancel[0] -> IDLE, outputs 0.
//   2. Line 1: dial, pickup_call after 2 cycles -> in_call[1]=1; hold 250 cycles -> call_timeout[1]=1
//      and call_ended[1]=1; end_call asserted on cycle 250 instead -> call_ended[1] for 1 cycle, IDLE.
//   3. dial=4'b1111 same cycle, MAX_TRUNKS=2 -> lines 0,1 DIAL, lines 2,3 busy_tone=1, active_calls=2.
//   4. Trunks full; line 0 end_call -> END_CALL; line 2 cancels BUSY and re-dials the cycle after
//      line 0 leaves IN_CALL -> line 2 granted (DIAL), not granted if dial coincides with release.
//   5. pickup_call and timeout on the same DIAL cycle -> IN_CALL; cancel and pickup same cycle -> IN_CALL.
//   6. preset pulse mid-call on two lines (async, between edges) -> all outputs 0 and active_calls=0
//      before next pclk edge; normal dial accepted after release.

Source files
------------

// File: rtl/telephone_trunk_ctrl_if.sv
// Line-side events into the trunk controller and its per-line tone/status outputs.
interface telephone_trunk_ctrl_if #(
  parameter int unsigned N_LINES = 4
);
  localparam int unsigned CW = $clog2(N_LINES + 1);

  logic [N_LINES-1:0] dial;
  logic [N_LINES-1:0] pickup_call;
  logic [N_LINES-1:0] end_call;
  logic [N_LINES-1:0] cancel;
  logic [N_LINES-1:0] dial_tone;
  logic [N_LINES-1:0] in_call;
  logic [N_LINES-1:0] dial_timeout;
  logic [N_LINES-1:0] call_ended;
  logic [N_LINES-1:0] call_timeout;
  logic [N_LINES-1:0] busy_tone;
  logic [CW-1:0]      active_calls;

  modport master (
    output dial, pickup_call, end_call, cancel,
    input  dial_tone, in_call, dial_timeout, call_ended, call_timeout, busy_tone, active_calls
  );

  modport slave (
    input  dial, pickup_call, end_call, cancel,
    output dial_tone, in_call, dial_timeout, call_ended, call_timeout, busy_tone, active_calls
  );
endinterface

// File: rtl/telephone_trunk_ctrl.sv
// Per-line call FSMs with dial/call timers, sharing MAX_TRUNKS outgoing trunks.
module telephone_trunk_ctrl #(
  parameter int unsigned N_LINES      = 4,
  parameter int unsigned MAX_TRUNKS   = 2,
  parameter int unsigned DIAL_TIMEOUT = 5,
  parameter int unsigned CALL_TIMEOUT = 250
) (
  input  logic                 pclk,
  input  logic                 preset,
  telephone_trunk_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(N_LINES + 1);
  localparam int unsigned TW = $clog2(CALL_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDial    = 3'd1,
    StInCall  = 3'd2,
    StEndCall = 3'd3,
    StDialTo  = 3'd4,
    StCallTo  = 3'd5,
    StBusy    = 3'd6
  } line_state_e;

  line_state_e   state_q [N_LINES];
  line_state_e   state_d [N_LINES];
  logic [TW-1:0] tmr_q   [N_LINES];
  logic [TW-1:0] tmr_d   [N_LINES];
  logic [CW-1:0] act_q, act_d;
  logic [CW-1:0] free;
  logic [CW-1:0] grant_left;

  // Trunks freed this cycle only show up in act_q next cycle.
  always_comb begin
    if (act_q >= CW'(MAX_TRUNKS)) free = '0;
    else                          free = CW'(MAX_TRUNKS) - act_q;
  end

  always_comb begin
    grant_left = free;
    for (int i = 0; i < N_LINES; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        StIdle: begin
          if (bus.dial[i]) begin
            if (grant_left != '0) begin
              state_d[i] = StDial;
              grant_left = grant_left - CW'(1);
            end else begin
              state_d[i] = StBusy;
            end
          end
        end
        StDial: begin
          if (bus.pickup_call[i])                   state_d[i] = StInCall;
          else if (bus.cancel[i])                   state_d[i] = StIdle;
          else if (tmr_q[i] == TW'(DIAL_TIMEOUT - 1)) state_d[i] = StDialTo;
        end
        StInCall: begin
          if (bus.end_call[i])                      state_d[i] = StEndCall;
          else if (tmr_q[i] == TW'(CALL_TIMEOUT - 1)) state_d[i] = StCallTo;
        end
        StEndCall: state_d[i] = StIdle;
        StDialTo, StCallTo, StBusy: begin
          if (bus.cancel[i]) state_d[i] = StIdle;
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  // Timers only run in the two timed states, so they never wrap.
  always_comb begin
    for (int i = 0; i < N_LINES; i++) begin
      tmr_d[i] = '0;
      if (state_d[i] == state_q[i] && (state_q[i] == StDial || state_q[i] == StInCall)) begin
        tmr_d[i] = tmr_q[i] + TW'(1);
      end
    end
  end

  always_comb begin
    act_d = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (state_d[i] == StDial || state_d[i] == StInCall) act_d = act_d + CW'(1);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < N_LINES; i++) begin
        state_q[i] <= StIdle;
        tmr_q[i]   <= '0;
      end
      act_q <= '0;
    end else begin
      for (int i = 0; i < N_LINES; i++) begin
        state_q[i] <= state_d[i];
        tmr_q[i]   <= tmr_d[i];
      end
      act_q <= act_d;
    end
  end

  logic [N_LINES-1:0] dial_tone_v, in_call_v, dial_to_v, ended_v, call_to_v, busy_v;

  always_comb begin
    dial_tone_v = '0;
    in_call_v   = '0;
    dial_to_v   = '0;
    ended_v     = '0;
    call_to_v   = '0;
    busy_v      = '0;
    for (int i = 0; i < N_LINES; i++) begin
      dial_tone_v[i] = (state_q[i] == StDial);
      in_call_v[i]   = (state_q[i] == StInCall);
      dial_to_v[i]   = (state_q[i] == StDialTo);
      ended_v[i]     = (state_q[i] == StEndCall) || (state_q[i] == StCallTo);
      call_to_v[i]   = (state_q[i] == StCallTo);
      busy_v[i]      = (state_q[i] == StBusy);
    end
  end

  assign bus.dial_tone    = dial_tone_v;
  assign bus.in_call      = in_call_v;
  assign bus.dial_timeout = dial_to_v;
  assign bus.call_ended   = ended_v;
  assign bus.call_timeout = call_to_v;
  assign bus.busy_tone    = busy_v;
  assign bus.active_calls = act_q;
endmodule

// File: tb/tb_telephone_trunk_ctrl.sv
// Directed scenarios plus random traffic, checked against a call-progress model.
module tb_telephone_trunk_ctrl;
  localparam int N  = 4;
  localparam int MT = 2;
  localparam int DT = 5;
  localparam int CT = 250;

  logic pclk;
  logic preset;
  int   n_checks;
  int   n_pass;

  telephone_trunk_ctrl_if #(.N_LINES(N)) bus ();

  telephone_trunk_ctrl #(
    .N_LINES     (N),
    .MAX_TRUNKS  (MT),
    .DIAL_TIMEOUT(DT),
    .CALL_TIMEOUT(CT)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Model: each line's phase and the edge number at which it entered that phase.
  typedef enum int {MIdle, MDial, MTalk, MHangup, MDialTo, MCallTo, MBusy} mph_e;
  mph_e ph    [N];
  int   since [N];
  int   edge_no;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ph[i]    = MIdle;
      since[i] = edge_no;
    end
  endtask

  task automatic model_edge();
    mph_e nx [N];
    int   busy_trunks;
    int   avail;
    edge_no++;
    busy_trunks = 0;
    for (int i = 0; i < N; i++) if (ph[i] == MDial || ph[i] == MTalk) busy_trunks++;
    avail = MT - busy_trunks;
    for (int i = 0; i < N; i++) begin
      nx[i] = ph[i];
      case (ph[i])
        MIdle: if (bus.dial[i]) begin
          if (avail > 0) begin
            nx[i] = MDial;
            avail--;
          end else nx[i] = MBusy;
        end
        MDial: begin
          if (bus.pickup_call[i])          nx[i] = MTalk;
          else if (bus.cancel[i])          nx[i] = MIdle;
          else if (edge_no - since[i] == DT) nx[i] = MDialTo;
        end
        MTalk: begin
          if (bus.end_call[i])             nx[i] = MHangup;
          else if (edge_no - since[i] == CT) nx[i] = MCallTo;
        end
        MHangup: nx[i] = MIdle;
        default: if (bus.cancel[i]) nx[i] = MIdle;
      endcase
    end
    for (int i = 0; i < N; i++) begin
      if (nx[i] != ph[i]) begin
        ph[i]    = nx[i];
        since[i] = edge_no;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] e_dt, e_ic, e_dto, e_ce, e_cto, e_bt;
    int e_act;
    e_dt = '0; e_ic = '0; e_dto = '0; e_ce = '0; e_cto = '0; e_bt = '0;
    e_act = 0;
    for (int i = 0; i < N; i++) begin
      e_dt[i]  = (ph[i] == MDial);
      e_ic[i]  = (ph[i] == MTalk);
      e_dto[i] = (ph[i] == MDialTo);
      e_ce[i]  = (ph[i] == MHangup) || (ph[i] == MCallTo);
      e_cto[i] = (ph[i] == MCallTo);
      e_bt[i]  = (ph[i] == MBusy);
      if (ph[i] == MDial || ph[i] == MTalk) e_act++;
    end
    chk({tag, ".dial_tone"},    32'(bus.dial_tone),    32'(e_dt));
    chk({tag, ".in_call"},      32'(bus.in_call),      32'(e_ic));
    chk({tag, ".dial_timeout"}, 32'(bus.dial_timeout), 32'(e_dto));
    chk({tag, ".call_ended"},   32'(bus.call_ended),   32'(e_ce));
    chk({tag, ".call_timeout"}, 32'(bus.call_timeout), 32'(e_cto));
    chk({tag, ".busy_tone"},    32'(bus.busy_tone),    32'(e_bt));
    chk({tag, ".active_calls"}, 32'(bus.active_calls), 32'(e_act));
  endtask

  task automatic step(input logic [N-1:0] d, input logic [N-1:0] p, input logic [N-1:0] e,
                      input logic [N-1:0] c, input string tag);
    bus.dial        = d;
    bus.pickup_call = p;
    bus.end_call    = e;
    bus.cancel      = c;
    @(posedge pclk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int k = 0; k < n; k++) step('0, '0, '0, '0, tag);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    edge_no  = 0;
    preset   = 1'b1;
    bus.dial = '0; bus.pickup_call = '0; bus.end_call = '0; bus.cancel = '0;
    model_reset();
    repeat (2) @(posedge pclk);
    #2 preset = 1'b0;
    #1 check_all("reset");
    chk("reset.active_const", 32'(bus.active_calls), 32'd0);

    // 1: dial timeout after exactly DT cycles, then cancel
    step(4'b0001, '0, '0, '0, "t1.dial");
    chk("t1.dial_tone0", 32'(bus.dial_tone[0]), 32'd1);
    chk("t1.active1", 32'(bus.active_calls), 32'd1);
    idle_steps(DT - 1, "t1.hold");
    chk("t1.still_dial", 32'(bus.dial_tone[0]), 32'd1);
    step('0, '0, '0, '0, "t1.to");
    chk("t1.dial_timeout0", 32'(bus.dial_timeout[0]), 32'd1);
    chk("t1.active0", 32'(bus.active_calls), 32'd0);
    step('0, '0, '0, 4'b0001, "t1.cancel");
    chk("t1.idle", 32'({bus.dial_tone, bus.dial_timeout, bus.busy_tone}), 32'd0);

    // 2: call timeout, then end_call on the timeout cycle
    step(4'b0010, '0, '0, '0, "t2.dial");
    step('0, '0, '0, '0, "t2.wait");
    step('0, 4'b0010, '0, '0, "t2.pickup");
    chk("t2.in_call1", 32'(bus.in_call[1]), 32'd1);
    idle_steps(CT - 1, "t2.hold");
    chk("t2.still_in_call", 32'(bus.in_call[1]), 32'd1);
    step('0, '0, '0, '0, "t2.to");
    chk("t2.call_timeout1", 32'(bus.call_timeout[1]), 32'd1);
    chk("t2.call_ended1", 32'(bus.call_ended[1]), 32'd1);
    step('0, '0, '0, 4'b0010, "t2.cancel");
    step(4'b0010, '0, '0, '0, "t2b.dial");
    step('0, 4'b0010, '0, '0, "t2b.pickup");
    idle_steps(CT - 1, "t2b.hold");
    step('0, '0, 4'b0010, '0, "t2b.end");
    chk("t2b.ended", 32'(bus.call_ended[1]), 32'd1);
    chk("t2b.no_to", 32'(bus.call_timeout[1]), 32'd0);
    step('0, '0, '0, '0, "t2b.idle");
    chk("t2b.ended_gone", 32'(bus.call_ended[1]), 32'd0);

    // 3: all four dial together, only two trunks
    step(4'b1111, '0, '0, '0, "t3.dial_all");
    chk("t3.dial_tone", 32'(bus.dial_tone), 32'h3);
    chk("t3.busy", 32'(bus.busy_tone), 32'hc);
    chk("t3.active", 32'(bus.active_calls), 32'd2);
    step('0, 4'b0011, '0, '0, "t3.pickup");

    // 4: release and re-dial timing
    step('0, '0, '0, 4'b1100, "t4.cancel_busy");
    step(4'b0100, '0, 4'b0001, '0, "t4.coincide");
    chk("t4.not_granted", 32'(bus.busy_tone[2]), 32'd1);
    step('0, '0, '0, 4'b0100, "t4.cancel2");
    step(4'b0100, '0, '0, '0, "t4.redial");
    chk("t4.granted", 32'(bus.dial_tone[2]), 32'd1);
    chk("t4.active", 32'(bus.active_calls), 32'd2);

    // 6: async reset pulse between edges while lines 1,2 are busy
    #1 preset = 1'b1;
    #1 chk("t6.async_outs", 32'({bus.dial_tone, bus.in_call, bus.busy_tone}), 32'd0);
    chk("t6.async_active", 32'(bus.active_calls), 32'd0);
    #1 preset = 1'b0;
    model_reset();
    #1 check_all("t6.after");

    // 5: pickup wins on timeout cycle; pickup beats cancel
    step(4'b0001, '0, '0, '0, "t5.dial");
    chk("t6.dial_after_reset", 32'(bus.dial_tone[0]), 32'd1);
    idle_steps(DT - 1, "t5.hold");
    step('0, 4'b0001, '0, '0, "t5.pickup_to");
    chk("t5.in_call0", 32'(bus.in_call[0]), 32'd1);
    step(4'b0010, '0, '0, '0, "t5.dial1");
    step('0, 4'b0010, '0, 4'b0010, "t5.pick_cancel");
    chk("t5.in_call1", 32'(bus.in_call[1]), 32'd1);
    step('0, '0, 4'b0011, '0, "t5.end");
    step('0, '0, '0, '0, "t5.idle");

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      logic [N-1:0] d, p, e, c;
      for (int i = 0; i < N; i++) begin
        d[i] = ($urandom_range(0, 2) == 0);
        p[i] = ($urandom_range(0, 7) == 0);
        e[i] = ($urandom_range(0, 15) == 0);
        c[i] = ($urandom_range(0, 5) == 0);
      end
      step(d, p, e, c, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
